// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the multicycle control unit:
//   - alu_ctrl_e   : ALU operation codes driven on CONTROL
//   - state_e      : control FSM states
//   - OP_*         : legal major opcodes (instruction bits [6:0])
//   - opcode_legal : opcode / branch-funct3 legality test used in DECODE
package alu_pkg;

  // Codes 1011 and 1111 are deliberately absent so they can never be issued.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_SLT  = 4'b0100,
    ALU_SUB  = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_XOR  = 4'b1001,
    ALU_SRL  = 4'b1010,
    ALU_SLTU = 4'b1100,
    ALU_SRA  = 4'b1110
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Branch funct3 010/011 have no defined comparison and are rejected.
  function automatic logic opcode_legal(input logic [6:0] op, input logic [2:0] f3);
    logic legal;
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_JAL: legal = 1'b1;
      OP_BRANCH:                              legal = (f3[2:1] != 2'b01);
      default:                                legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/decodificador_alu.sv
// decodificador_alu
// Combinational funct3/funct7 to ALU-operation mapping for R and I-ALU
// instructions.
// Ports:
//   funct3   in  3  instruction bits [14:12]
//   funct7_5 in  1  instruction bit 30 (selects SUB / SRA)
//   is_r     in  1  instruction is register-register (only then may 000 be SUB)
//   control  out 4  ALU operation code
module decodificador_alu
  import alu_pkg::*;
(
  input  logic      [2:0] funct3,
  input  logic            funct7_5,
  input  logic            is_r,
  output alu_ctrl_e       control
);

  always_comb begin
    control = ALU_ADD;
    case (funct3)
      3'b000:  control = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  control = ALU_SLL;
      3'b010:  control = ALU_SLT;
      3'b011:  control = ALU_SLTU;
      3'b100:  control = ALU_XOR;
      // Bit 30 selects arithmetic shift for both srai and sra.
      3'b101:  control = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  control = ALU_OR;
      default: control = ALU_AND;
    endcase
  end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// unidad_control_multiciclo
// Five-state (FETCH, DECODE, EXEC, MEM, WB) control unit for a multicycle
// RV32I-subset datapath (R, I-ALU, LOAD, STORE, BRANCH, JAL).
// Ports:
//   CLK        in   1     system clock, rising edge
//   RST_N      in   1     asynchronous active-low reset
//   INSTR      in   size  instruction-memory read data
//   MEM_READY  in   1     memory access completes this cycle
//   ZERO       in   1     ALU zero flag
//   CONTROL    out  4     ALU operation code
//   ALU_SRC_A  out  2     00=rs1, 01=PC, 10=OLDPC
//   ALU_SRC_B  out  2     00=rs2, 01=imm, 10=constant 4
//   IR_WRITE, PC_WRITE, MEM_REQ, MEM_WE, REG_WRITE  out 1  strobes
//   PC_SRC     out  1     0=ALU result, 1=ALUOut register
//   WB_SEL     out  2     00=ALUOut, 01=memory data, 10=PC+4
//   ILLEGAL    out  1     one-cycle pulse on an undecodable instruction
module unidad_control_multiciclo
  import alu_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [size-1:0] INSTR,
  input  logic            MEM_READY,
  input  logic            ZERO,
  output logic [3:0]      CONTROL,
  output logic [1:0]      ALU_SRC_A,
  output logic [1:0]      ALU_SRC_B,
  output logic            IR_WRITE,
  output logic            PC_WRITE,
  output logic            MEM_REQ,
  output logic            MEM_WE,
  output logic            REG_WRITE,
  output logic            PC_SRC,
  output logic [1:0]      WB_SEL,
  output logic            ILLEGAL
);

  state_e          state_reg, state_next;
  logic [size-1:0] ir_reg;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  alu_ctrl_e  alu_op;

  assign opcode   = ir_reg[6:0];
  assign funct3   = ir_reg[14:12];
  assign funct7_5 = ir_reg[30];

  // Register/immediate fields are consumed by the datapath, not here.
  logic unused_ir;
  assign unused_ir = ^{ir_reg[size-1:31], ir_reg[29:15], ir_reg[11:7]};

  decodificador_alu u_decodificador_alu (
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .is_r     (opcode == OP_R),
    .control  (alu_op)
  );

  // Raw decode before the reset gate.
  alu_ctrl_e  control_c;
  logic [1:0] src_a_c, src_b_c, wb_sel_c;
  logic       ir_write_c, pc_write_c, mem_req_c, mem_we_c;
  logic       reg_write_c, pc_src_c, illegal_c;
  logic       branch_taken;
  alu_ctrl_e  branch_op;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= FETCH;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (ir_write_c) ir_reg <= INSTR;
    end
  end

  // Branch comparison: SUB gives equality via ZERO, SLT/SLTU give 1 (ZERO=0)
  // when rs1 < rs2.
  always_comb begin
    branch_op    = ALU_ADD;
    branch_taken = 1'b0;
    case (funct3)
      3'b000: begin branch_op = ALU_SUB;  branch_taken = ZERO;  end
      3'b001: begin branch_op = ALU_SUB;  branch_taken = !ZERO; end
      3'b100: begin branch_op = ALU_SLT;  branch_taken = !ZERO; end
      3'b101: begin branch_op = ALU_SLT;  branch_taken = ZERO;  end
      3'b110: begin branch_op = ALU_SLTU; branch_taken = !ZERO; end
      3'b111: begin branch_op = ALU_SLTU; branch_taken = ZERO;  end
      default: ;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    control_c   = ALU_ADD;
    src_a_c     = 2'b00;
    src_b_c     = 2'b00;
    wb_sel_c    = 2'b00;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    reg_write_c = 1'b0;
    pc_src_c    = 1'b0;
    illegal_c   = 1'b0;

    case (state_reg)
      FETCH: begin
        mem_req_c = 1'b1;
        src_a_c   = 2'b01;
        src_b_c   = 2'b10;
        if (MEM_READY) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_next = DECODE;
        end
      end

      DECODE: begin
        if (opcode_legal(opcode, funct3)) begin
          // Precompute OLDPC+imm into ALUOut for branches and JAL.
          src_a_c    = 2'b10;
          src_b_c    = 2'b01;
          state_next = EXEC;
        end else begin
          illegal_c  = 1'b1;
          state_next = FETCH;
        end
      end

      EXEC: begin
        state_next = FETCH;
        case (opcode)
          OP_R: begin
            control_c  = alu_op;
            state_next = WB;
          end
          OP_I: begin
            control_c  = alu_op;
            src_b_c    = 2'b01;
            state_next = WB;
          end
          OP_LOAD, OP_STORE: begin
            src_b_c    = 2'b01;
            state_next = MEM;
          end
          OP_BRANCH: begin
            control_c  = branch_op;
            pc_write_c = branch_taken;
            pc_src_c   = branch_taken;
          end
          OP_JAL: begin
            pc_write_c  = 1'b1;
            pc_src_c    = 1'b1;
            reg_write_c = 1'b1;
            wb_sel_c    = 2'b10;
          end
          default: ;
        endcase
      end

      MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = (opcode == OP_STORE);
        if (MEM_READY) state_next = (opcode == OP_LOAD) ? WB : FETCH;
      end

      WB: begin
        reg_write_c = 1'b1;
        wb_sel_c    = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
        state_next  = FETCH;
      end

      default: state_next = FETCH;
    endcase
  end

  // The state register alone cannot silence FETCH's MEM_REQ while RST_N is
  // low, so every output is also gated by RST_N to quiet the bus at once.
  assign CONTROL   = RST_N ? control_c   : ALU_ADD;
  assign ALU_SRC_A = RST_N ? src_a_c     : 2'b00;
  assign ALU_SRC_B = RST_N ? src_b_c     : 2'b00;
  assign WB_SEL    = RST_N ? wb_sel_c    : 2'b00;
  assign IR_WRITE  = RST_N & ir_write_c;
  assign PC_WRITE  = RST_N & pc_write_c;
  assign MEM_REQ   = RST_N & mem_req_c;
  assign MEM_WE    = RST_N & mem_we_c;
  assign REG_WRITE = RST_N & reg_write_c;
  assign PC_SRC    = RST_N & pc_src_c;
  assign ILLEGAL   = RST_N & illegal_c;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Directed testbench for unidad_control_multiciclo. Inputs change 1 ns after
// the rising edge, outputs are sampled 1 ns later.
module tb_unidad_control_multiciclo;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] INSTR;
  logic        MEM_READY;
  logic        ZERO;
  logic [3:0]  CONTROL;
  logic [1:0]  ALU_SRC_A, ALU_SRC_B, WB_SEL;
  logic        IR_WRITE, PC_WRITE, MEM_REQ, MEM_WE, REG_WRITE, PC_SRC, ILLEGAL;

  int check_count = 0;
  int pass_count  = 0;

  always #5 CLK = ~CLK;

  unidad_control_multiciclo #(.size(32)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .INSTR     (INSTR),
    .MEM_READY (MEM_READY),
    .ZERO      (ZERO),
    .CONTROL   (CONTROL),
    .ALU_SRC_A (ALU_SRC_A),
    .ALU_SRC_B (ALU_SRC_B),
    .IR_WRITE  (IR_WRITE),
    .PC_WRITE  (PC_WRITE),
    .MEM_REQ   (MEM_REQ),
    .MEM_WE    (MEM_WE),
    .REG_WRITE (REG_WRITE),
    .PC_SRC    (PC_SRC),
    .WB_SEL    (WB_SEL),
    .ILLEGAL   (ILLEGAL)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      pass_count++;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Current state must be FETCH; completes the fetch and leaves DECODE active
  // with INSTR cleared so later decode relies on the captured IR.
  task automatic do_fetch(input logic [31:0] instr);
    INSTR = instr;
    MEM_READY = 1'b1;
    #1;
    check("fetch_mem_req", MEM_REQ, 1);
    check("fetch_ir_write", IR_WRITE, 1);
    check("fetch_pc_write", PC_WRITE, 1);
    check("fetch_pc_src", PC_SRC, 0);
    check("fetch_src_a", ALU_SRC_A, 2'b01);
    check("fetch_src_b", ALU_SRC_B, 2'b10);
    tick();
    MEM_READY = 1'b0;
    INSTR = 32'h0;
  endtask

  // Checks that the FSM is back in FETCH (waiting, MEM_READY=0).
  task automatic expect_fetch(input string tag);
    #1;
    check({tag, "_back_mem_req"}, MEM_REQ, 1);
    check({tag, "_back_src_a"}, ALU_SRC_A, 2'b01);
    check({tag, "_back_src_b"}, ALU_SRC_B, 2'b10);
    check({tag, "_back_reg_write"}, REG_WRITE, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; MEM_READY = 1'b0; ZERO = 1'b0; INSTR = 32'h0;
    repeat (2) @(posedge CLK);
    #2;
    check("rst_mem_req", MEM_REQ, 0);
    check("rst_control", CONTROL, 4'b0000);
    check("rst_src_a", ALU_SRC_A, 0);
    check("rst_src_b", ALU_SRC_B, 0);
    check("rst_ir_write", IR_WRITE, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    check("post_rst_mem_req", MEM_REQ, 1);
    check("post_rst_ir_write", IR_WRITE, 0);
    // Reset asserted mid-FETCH must silence outputs before the next edge.
    RST_N = 1'b0;
    #1;
    check("rst_fetch_mem_req", MEM_REQ, 0);
    check("rst_fetch_control", CONTROL, 4'b0000);
    check("rst_fetch_src_a", ALU_SRC_A, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    $display("txn reset: done");

    // sub x0,x1,x2
    do_fetch(32'h40208033);
    #1;
    check("sub_dec_control", CONTROL, 4'b0000);
    check("sub_dec_src_a", ALU_SRC_A, 2'b10);
    check("sub_dec_src_b", ALU_SRC_B, 2'b01);
    check("sub_dec_illegal", ILLEGAL, 0);
    tick(); #1;
    check("sub_exec_control", CONTROL, 4'b0111);
    check("sub_exec_src_a", ALU_SRC_A, 0);
    check("sub_exec_src_b", ALU_SRC_B, 0);
    check("sub_exec_reg_write", REG_WRITE, 0);
    tick(); #1;
    check("sub_wb_reg_write", REG_WRITE, 1);
    check("sub_wb_sel", WB_SEL, 2'b00);
    tick();
    expect_fetch("sub");
    $display("txn sub 40208033: done");

    // srai x1,x1,2
    do_fetch(32'h4020D093);
    tick(); #1;
    check("srai_exec_control", CONTROL, 4'b1110);
    check("srai_exec_src_b", ALU_SRC_B, 2'b01);
    tick(); #1;
    check("srai_wb_reg_write", REG_WRITE, 1);
    tick();
    expect_fetch("srai");
    $display("txn srai 4020D093: done");

    // addi with bit30 set stays ADD (no SUB for immediates)
    do_fetch(32'h40008093);
    tick(); #1;
    check("addi_exec_control", CONTROL, 4'b0000);
    tick(); tick();
    $display("txn addi 40008093: done");

    // bne, ZERO=0 -> taken, then ZERO=1 -> not taken
    do_fetch(32'h00209463);
    tick();
    ZERO = 1'b0; #1;
    check("bne_t_control", CONTROL, 4'b0111);
    check("bne_t_pc_write", PC_WRITE, 1);
    check("bne_t_pc_src", PC_SRC, 1);
    tick();
    expect_fetch("bne_t");
    do_fetch(32'h00209463);
    tick();
    ZERO = 1'b1; #1;
    check("bne_nt_pc_write", PC_WRITE, 0);
    tick();
    ZERO = 1'b0;
    expect_fetch("bne_nt");
    $display("txn bne 00209463: done");

    // blt ZERO=0 -> taken; bltu ZERO=1 -> not taken
    do_fetch(32'h0020C463);
    tick(); #1;
    check("blt_control", CONTROL, 4'b0100);
    check("blt_pc_write", PC_WRITE, 1);
    tick();
    do_fetch(32'h0020E463);
    tick();
    ZERO = 1'b1; #1;
    check("bltu_control", CONTROL, 4'b1100);
    check("bltu_pc_write", PC_WRITE, 0);
    tick();
    ZERO = 1'b0;
    $display("txn blt/bltu: done");

    // lw with 3 wait cycles in MEM
    do_fetch(32'h0040A183);
    tick(); #1;
    check("lw_exec_control", CONTROL, 4'b0000);
    check("lw_exec_src_b", ALU_SRC_B, 2'b01);
    check("lw_exec_src_a", ALU_SRC_A, 2'b00);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lw_mem_wait_req", MEM_REQ, 1);
      check("lw_mem_wait_we", MEM_WE, 0);
      tick();
    end
    MEM_READY = 1'b1; #1;
    check("lw_mem_ready_req", MEM_REQ, 1);
    check("lw_mem_src_a", ALU_SRC_A, 2'b00);
    tick();
    MEM_READY = 1'b0; #1;
    check("lw_wb_reg_write", REG_WRITE, 1);
    check("lw_wb_sel", WB_SEL, 2'b01);
    tick();
    expect_fetch("lw");
    $display("txn lw 0040A183: done");

    // sw with zero-wait memory
    do_fetch(32'h0020A223);
    tick(); tick();
    MEM_READY = 1'b1; #1;
    check("sw_mem_req", MEM_REQ, 1);
    check("sw_mem_we", MEM_WE, 1);
    tick();
    MEM_READY = 1'b0;
    expect_fetch("sw");
    $display("txn sw 0020A223: done");

    // jal x1,8
    do_fetch(32'h008000EF);
    tick(); #1;
    check("jal_pc_write", PC_WRITE, 1);
    check("jal_pc_src", PC_SRC, 1);
    check("jal_reg_write", REG_WRITE, 1);
    check("jal_wb_sel", WB_SEL, 2'b10);
    tick();
    expect_fetch("jal");
    $display("txn jal 008000EF: done");

    // illegal opcode
    do_fetch(32'h0000007F);
    #1;
    check("ill_illegal", ILLEGAL, 1);
    check("ill_pc_write", PC_WRITE, 0);
    check("ill_reg_write", REG_WRITE, 0);
    check("ill_mem_req", MEM_REQ, 0);
    tick();
    check("ill_after_illegal", ILLEGAL, 0);
    expect_fetch("ill");
    // branch funct3 010 is illegal too
    do_fetch(32'h0020A463);
    #1;
    check("ill_br_illegal", ILLEGAL, 1);
    tick();
    expect_fetch("ill_br");
    $display("txn illegal: done");

    // reset during a stalled MEM access returns to FETCH
    do_fetch(32'h0040A183);
    tick(); tick(); #1;
    check("rst_mem_pre_req", MEM_REQ, 1);
    RST_N = 1'b0; #1;
    check("rst_mem_req", MEM_REQ, 0);
    check("rst_mem_we", MEM_WE, 0);
    @(negedge CLK);
    RST_N = 1'b1; #1;
    check("rst_mem_fetch_src_a", ALU_SRC_A, 2'b01);
    check("rst_mem_fetch_src_b", ALU_SRC_B, 2'b10);
    $display("txn reset_in_mem: done");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
